tick_prescaler: RTL and testbench
=================================

// Module: tick_prescaler
// PURPOSE
//   Programmable clock-enable generator that sits directly upstream of the 8-bit event counter.
//   - Divides clk by a runtime divisor N.
//   - Emits a single-cycle 'tick' every N cycles while running; the counter increments on tick.
//   - Start/stop control FSM.
//   - Divisor is double-buffered, so a new N never truncates a period in progress.
// PARAMETERS
//   WIDTH    8   width of divisor, shadow register and internal count
//   DEF_DIV  10  divisor loaded into active and shadow registers at reset
// PORTS
//   clk       in   1      single clock, all state updates on posedge
//   rst       in   1      reset; asynchronous, active-high
//   start     in   1      level sampled each edge; IDLE->RUN request
//   stop      in   1      level sampled each edge; any state -> IDLE
//   div_wr    in   1      write strobe for div_val into shadow register
//   div_val   in   WIDTH  new divisor N
//   tick      out  1      registered one-cycle enable pulse, period N
//   busy      out  1      1 while state != IDLE
//   div_act   out  WIDTH  divisor currently in force
//   cnt       out  WIDTH  internal phase count, 0..term
// BEHAVIOUR
//   Reset (async, immediate): state=IDLE, cnt=0, tick=0, busy=0, div_act=shadow=DEF_DIV, pend=0.
//   term = (div_act<=1) ? 0 : div_act-1; N=0 and N=1 both give a tick every cycle.
//   States IDLE, RUN (+ONE with option). busy is registered and equals (next state != IDLE).
//   IDLE:
//     - cnt=0, tick=0.
//     - start & !stop -> RUN, cnt=0.
//   RUN, each edge:
//     - cnt==term -> cnt<=0, tick<=1.
//     - else cnt<=cnt+1, tick<=0.
//     - First tick is high exactly N cycles after the start edge (N=4: start at E0, tick high E4-E5).
//   stop:
//     - Priority over everything else; stop & start together -> IDLE.
//     - stop -> IDLE, cnt<=0, tick<=0; a tick due on that same edge is suppressed.
//   start while RUN: ignored; no phase restart.
//   div_wr:
//     - Any state: shadow<=div_val, pend<=1.
//     - Same-edge div_wr twice is impossible; the last write before transfer wins.
//   Shadow transfer (div_act<=shadow, pend<=0):
//     - In RUN, only on the edge where cnt==term.
//     - In IDLE, on the next edge.
//     - div_wr coincident with a transfer edge writes shadow; the transfer uses the OLD shadow; pend stays 1.
//   Counter width: cnt never exceeds term; no wrap beyond term; WIDTH-bit arithmetic only.
// CONFIGURATION
//   PRESCALER_ONESHOT_EN defined:
//     - Adds input 'oneshot' (1 bit).
//     - start & oneshot in IDLE -> state ONE; counts as RUN, emits exactly one tick, then -> IDLE
//       on the same edge that sets tick (busy falls with tick rise).
//     - stop aborts ONE identically to RUN.
//   PRESCALER_ONESHOT_EN undefined:
//     - Port absent, ONE state absent; start always enters continuous RUN.
// STRUCTURE
//   Package prescaler_pkg:
//     - typedef enum logic [1:0] {PS_IDLE, PS_RUN, PS_ONE} ps_state_t.
//     - localparam PS_DEF_WIDTH=8, PS_DEF_DIV=10.
//   Sub-module prescaler_shadow_reg: shadow register, pend flag, active-divisor transfer logic.
//   The top holds the FSM and phase counter.
// TESTING
//   1. rst high 3 cycles, then low -> tick=0, busy=0, div_act=10, cnt=0; rst mid-RUN clears all asynchronously.
//   2. div_wr with div_val=4, start 1 cycle -> ticks on cycles 4,8,12 after start, each 1 cycle wide.
//   3. RUN with N=4; write div_val=2 at cnt=1 -> next tick still after 4 cycles; then period 2; div_act changes on that tick edge.
//   4. div_val=0 and again div_val=1 -> tick high every cycle in RUN; busy=1.
//   5. start & stop asserted together in IDLE -> stays IDLE; stop on terminal edge in RUN -> no tick, cnt=0, busy=0.
//   6. [PRESCALER_ONESHOT_EN] N=3, start & oneshot -> exactly one tick 3 cycles later, then busy=0, no further ticks.

Source files
------------

// File: rtl/tick_prescaler_pkg.sv
// rtl/tick_prescaler_pkg.sv - shared types and defaults for the tick prescaler
// Contents:
//   ps_state_t   control FSM encoding (PS_ONE is used only with PRESCALER_ONESHOT_EN)
//   PS_DEF_WIDTH default divisor / counter width
//   PS_DEF_DIV   default divisor loaded at reset
package prescaler_pkg;

  typedef enum logic [1:0] {PS_IDLE, PS_RUN, PS_ONE} ps_state_t;

  localparam int PS_DEF_WIDTH = 8;
  localparam int PS_DEF_DIV   = 10;

endpackage

// File: rtl/tick_prescaler_if.sv
// rtl/tick_prescaler_if.sv - control/status bundle of the tick prescaler
// Signals:
//   start, stop  run control levels, sampled every edge
//   oneshot      single-tick request qualifier (only with PRESCALER_ONESHOT_EN)
//   div_wr       write strobe for div_val into the shadow divisor
//   div_val      new divisor N
//   tick         one-cycle clock-enable pulse
//   busy         high while the FSM is not idle
//   div_act      divisor currently in force
//   cnt          phase count, 0..term
// Modports: master drives the controls, slave is the prescaler.
interface tick_prescaler_if #(
  parameter int WIDTH = prescaler_pkg::PS_DEF_WIDTH
);
  logic             start;
  logic             stop;
`ifdef PRESCALER_ONESHOT_EN
  logic             oneshot;
`endif
  logic             div_wr;
  logic [WIDTH-1:0] div_val;
  logic             tick;
  logic             busy;
  logic [WIDTH-1:0] div_act;
  logic [WIDTH-1:0] cnt;

  modport master (
`ifdef PRESCALER_ONESHOT_EN
    output oneshot,
`endif
    output start, stop, div_wr, div_val,
    input  tick, busy, div_act, cnt
  );

  modport slave (
`ifdef PRESCALER_ONESHOT_EN
    input  oneshot,
`endif
    input  start, stop, div_wr, div_val,
    output tick, busy, div_act, cnt
  );
endinterface

// File: rtl/tick_prescaler_shadow_reg.sv
// rtl/tick_prescaler_shadow_reg.sv - double-buffered divisor (shadow, pend, active)
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   div_wr    write strobe, loads div_val into the shadow register
//   div_val   new divisor
//   xfer      this edge may move shadow into the active divisor
//   div_act   divisor currently in force
module prescaler_shadow_reg #(
  parameter int WIDTH   = prescaler_pkg::PS_DEF_WIDTH,
  parameter int DEF_DIV = prescaler_pkg::PS_DEF_DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_wr,
  input  logic [WIDTH-1:0] div_val,
  input  logic             xfer,
  output logic [WIDTH-1:0] div_act
);

  logic [WIDTH-1:0] shadow;
  logic             pend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow  <= WIDTH'(DEF_DIV);
      div_act <= WIDTH'(DEF_DIV);
      pend    <= 1'b0;
    end else begin
      if (div_wr) begin
        shadow <= div_val;
      end
      // A write landing on a transfer edge updates shadow but the transfer
      // takes the old shadow value, so the new write stays pending.
      if (xfer && pend) begin
        div_act <= shadow;
        pend    <= div_wr;
      end else if (div_wr) begin
        pend <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - programmable clock-enable generator with start/stop FSM
// Ports:
//   clk   single clock, posedge
//   rst   asynchronous active-high reset
//   bus   tick_prescaler_if.slave (start/stop/div_wr/div_val in; tick/busy/div_act/cnt out)
// Option: PRESCALER_ONESHOT_EN adds bus.oneshot and the single-tick ONE state.
module tick_prescaler
  import prescaler_pkg::*;
#(
  parameter int WIDTH   = PS_DEF_WIDTH,
  parameter int DEF_DIV = PS_DEF_DIV
) (
  input  logic              clk,
  input  logic              rst,
  tick_prescaler_if.slave   bus
);

  ps_state_t        state, state_n;
  logic [WIDTH-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] term;
  logic [WIDTH-1:0] div_act;
  logic             tick, tick_n;
  logic             busy;
  logic             at_term;
  logic             xfer;

  // N=0 and N=1 both collapse to a one-cycle period.
  assign term    = (div_act <= WIDTH'(1)) ? '0 : div_act - WIDTH'(1);
  assign at_term = (cnt == term);
  // Shadow moves in only at a period boundary, or freely while idle.
  assign xfer    = (state == PS_IDLE) || at_term;

  prescaler_shadow_reg #(
    .WIDTH   (WIDTH),
    .DEF_DIV (DEF_DIV)
  ) u_shadow (
    .clk     (clk),
    .rst     (rst),
    .div_wr  (bus.div_wr),
    .div_val (bus.div_val),
    .xfer    (xfer),
    .div_act (div_act)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    tick_n  = 1'b0;
    if (bus.stop) begin
      // stop wins over start and suppresses a tick due on this edge
      state_n = PS_IDLE;
      cnt_n   = '0;
    end else begin
      case (state)
        PS_IDLE: begin
          cnt_n = '0;
          if (bus.start) begin
`ifdef PRESCALER_ONESHOT_EN
            state_n = bus.oneshot ? PS_ONE : PS_RUN;
`else
            state_n = PS_RUN;
`endif
          end
        end
        PS_RUN: begin
          if (at_term) begin
            cnt_n  = '0;
            tick_n = 1'b1;
          end else begin
            cnt_n = cnt + WIDTH'(1);
          end
        end
`ifdef PRESCALER_ONESHOT_EN
        PS_ONE: begin
          if (at_term) begin
            cnt_n   = '0;
            tick_n  = 1'b1;
            state_n = PS_IDLE;
          end else begin
            cnt_n = cnt + WIDTH'(1);
          end
        end
`endif
        default: begin
          state_n = PS_IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= PS_IDLE;
      cnt   <= '0;
      tick  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      tick  <= tick_n;
      busy  <= (state_n != PS_IDLE);
    end
  end

  assign bus.tick    = tick;
  assign bus.busy    = busy;
  assign bus.cnt     = cnt;
  assign bus.div_act = div_act;

endmodule

// File: tb/tb_tick_prescaler.sv
// tb/tb_tick_prescaler.sv - directed self-checking bench for tick_prescaler
module tb_tick_prescaler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  tick_prescaler_if #(.WIDTH(8)) bus ();

  tick_prescaler #(.WIDTH(8), .DEF_DIV(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // advance one edge and settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.start = 0; bus.stop = 0; bus.div_wr = 0; bus.div_val = 0;
`ifdef PRESCALER_ONESHOT_EN
    bus.oneshot = 0;
`endif
    rst = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    n_tests++; if (bus.tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick got %0d exp 0", bus.tick); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0d exp 0", bus.busy); end
    n_tests++; if (bus.div_act !== 8'd10) begin n_fail++; $display("FAIL reset_div_act got %0d exp 10", bus.div_act); end
    n_tests++; if (bus.cnt !== 8'd0) begin n_fail++; $display("FAIL reset_cnt got %0d exp 0", bus.cnt); end
    // run with the default divisor, then reset asynchronously between edges
    bus.start = 1; step(); bus.start = 0;
    step(); step(); step();
    n_tests++; if (bus.cnt !== 8'd3) begin n_fail++; $display("FAIL run_cnt got %0d exp 3", bus.cnt); end
    n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL run_busy got %0d exp 1", bus.busy); end
    #2 rst = 1;
    #1;
    n_tests++; if (bus.cnt !== 8'd0) begin n_fail++; $display("FAIL async_cnt got %0d exp 0", bus.cnt); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL async_busy got %0d exp 0", bus.busy); end
    @(posedge clk); #1 rst = 0;
    step();
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy got %0d exp 0", bus.busy); end
  endtask

  task automatic test_basic_div4();
    bus.div_wr = 1; bus.div_val = 8'd4; step(); bus.div_wr = 0;
    bus.start = 1; step(); bus.start = 0;
    n_tests++; if (bus.div_act !== 8'd4) begin n_fail++; $display("FAIL div4_act got %0d exp 4", bus.div_act); end
    for (int k = 1; k <= 12; k++) begin
      step();
      n_tests++; if (bus.tick !== ((k % 4) == 0)) begin n_fail++; $display("FAIL div4_tick k=%0d got %0d exp %0d", k, bus.tick, (k % 4) == 0); end
      n_tests++; if (bus.cnt !== 8'(k % 4)) begin n_fail++; $display("FAIL div4_cnt k=%0d got %0d exp %0d", k, bus.cnt, k % 4); end
      n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL div4_busy k=%0d got %0d exp 1", k, bus.busy); end
    end
  endtask

  // continues from test_basic_div4: running with N=4, just past a tick
  task automatic test_double_buffer();
    logic exp_tick [0:7];
    logic [7:0] exp_act [0:7];
    exp_tick = '{0, 0, 1, 0, 1, 0, 1, 0};
    exp_act  = '{8'd4, 8'd4, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2};
    step();
    n_tests++; if (bus.cnt !== 8'd1) begin n_fail++; $display("FAIL dbuf_cnt got %0d exp 1", bus.cnt); end
    bus.div_wr = 1; bus.div_val = 8'd2;
    for (int k = 0; k < 8; k++) begin
      step();
      bus.div_wr = 0;
      n_tests++; if (bus.tick !== exp_tick[k]) begin n_fail++; $display("FAIL dbuf_tick k=%0d got %0d exp %0d", k, bus.tick, exp_tick[k]); end
      n_tests++; if (bus.div_act !== exp_act[k]) begin n_fail++; $display("FAIL dbuf_act k=%0d got %0d exp %0d", k, bus.div_act, exp_act[k]); end
    end
    bus.stop = 1; step(); bus.stop = 0;
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL dbuf_stop_busy got %0d exp 0", bus.busy); end
  endtask

  task automatic test_div_small();
    logic [7:0] vals [0:1];
    vals = '{8'd0, 8'd1};
    for (int v = 0; v < 2; v++) begin
      bus.div_wr = 1; bus.div_val = vals[v]; step(); bus.div_wr = 0;
      bus.start = 1; step(); bus.start = 0;
      n_tests++; if (bus.div_act !== vals[v]) begin n_fail++; $display("FAIL small_act got %0d exp %0d", bus.div_act, vals[v]); end
      for (int k = 0; k < 4; k++) begin
        step();
        n_tests++; if (bus.tick !== 1'b1) begin n_fail++; $display("FAIL small_tick n=%0d k=%0d got %0d exp 1", vals[v], k, bus.tick); end
        n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL small_busy n=%0d k=%0d got %0d exp 1", vals[v], k, bus.busy); end
        n_tests++; if (bus.cnt !== 8'd0) begin n_fail++; $display("FAIL small_cnt n=%0d k=%0d got %0d exp 0", vals[v], k, bus.cnt); end
      end
      bus.stop = 1; step(); bus.stop = 0;
      n_tests++; if (bus.tick !== 1'b0) begin n_fail++; $display("FAIL small_stop_tick got %0d exp 0", bus.tick); end
    end
  endtask

  task automatic test_stop();
    bus.start = 1; bus.stop = 1; step(); bus.start = 0; bus.stop = 0;
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL both_busy got %0d exp 0", bus.busy); end
    n_tests++; if (bus.cnt !== 8'd0) begin n_fail++; $display("FAIL both_cnt got %0d exp 0", bus.cnt); end
    step();
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL both_busy2 got %0d exp 0", bus.busy); end
    bus.div_wr = 1; bus.div_val = 8'd4; step(); bus.div_wr = 0;
    bus.start = 1; step(); bus.start = 0;
    step();
    // start while running must not restart the phase
    bus.start = 1; step(); bus.start = 0;
    n_tests++; if (bus.cnt !== 8'd2) begin n_fail++; $display("FAIL restart_cnt got %0d exp 2", bus.cnt); end
    step();
    n_tests++; if (bus.cnt !== 8'd3) begin n_fail++; $display("FAIL preterm_cnt got %0d exp 3", bus.cnt); end
    bus.stop = 1; step(); bus.stop = 0;
    n_tests++; if (bus.tick !== 1'b0) begin n_fail++; $display("FAIL stopterm_tick got %0d exp 0", bus.tick); end
    n_tests++; if (bus.cnt !== 8'd0) begin n_fail++; $display("FAIL stopterm_cnt got %0d exp 0", bus.cnt); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL stopterm_busy got %0d exp 0", bus.busy); end
    for (int k = 0; k < 5; k++) begin
      step();
      n_tests++; if (bus.tick !== 1'b0) begin n_fail++; $display("FAIL idle_tick k=%0d got %0d exp 0", k, bus.tick); end
    end
  endtask

`ifdef PRESCALER_ONESHOT_EN
  task automatic test_oneshot();
    logic exp_tick [0:7];
    logic exp_busy [0:7];
    exp_tick = '{0, 0, 1, 0, 0, 0, 0, 0};
    exp_busy = '{1, 1, 0, 0, 0, 0, 0, 0};
    bus.div_wr = 1; bus.div_val = 8'd3; step(); bus.div_wr = 0;
    bus.start = 1; bus.oneshot = 1; step(); bus.start = 0; bus.oneshot = 0;
    n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL one_busy0 got %0d exp 1", bus.busy); end
    for (int k = 0; k < 8; k++) begin
      step();
      n_tests++; if (bus.tick !== exp_tick[k]) begin n_fail++; $display("FAIL one_tick k=%0d got %0d exp %0d", k, bus.tick, exp_tick[k]); end
      n_tests++; if (bus.busy !== exp_busy[k]) begin n_fail++; $display("FAIL one_busy k=%0d got %0d exp %0d", k, bus.busy, exp_busy[k]); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_div4();
    test_double_buffer();
    test_div_small();
    test_stop();
`ifdef PRESCALER_ONESHOT_EN
    test_oneshot();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
